// File: rtl/tl_pkg.sv
// Shared state encoding, lamp bundle and sizing helpers for the intersection scheduler.
package tl_pkg;

  typedef enum logic [2:0] {
    ALLRED_BA = 3'd0,
    A_GREEN   = 3'd1,
    A_YELLOW  = 3'd2,
    ALLRED_AB = 3'd3,
    B_GREEN   = 3'd4,
    B_YELLOW  = 3'd5,
    PED_WALK  = 3'd6
  } state_t;

  typedef enum logic {
    DIR_A = 1'b0,
    DIR_B = 1'b1
  } dir_t;

  typedef struct packed {
    logic a_red;
    logic a_yellow;
    logic a_green;
    logic b_red;
    logic b_yellow;
    logic b_green;
    logic walk;
  } lamps_t;

  // Bits needed to count 0..n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic lamps_t lamp_decode(input state_t s);
    lamps_t l;
    l.a_green  = (s == A_GREEN);
    l.a_yellow = (s == A_YELLOW);
    l.a_red    = !(s == A_GREEN || s == A_YELLOW);
    l.b_green  = (s == B_GREEN);
    l.b_yellow = (s == B_YELLOW);
    l.b_red    = !(s == B_GREEN || s == B_YELLOW);
    l.walk     = (s == PED_WALK);
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_sec_tick_gen.sv
// One-second prescaler: tick pulses for one cycle when the count reaches CLK_HZ-1.
// clr restarts the second so each phase begins on a fresh boundary.
module sec_tick_gen
  import tl_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = cnt_width(CLK_HZ);
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Request-driven two-approach intersection scheduler with pedestrian walk phase.
// Lamps are registered from the next-state decode so they switch on the same edge as the state.
module traffic_phase_scheduler
  import tl_pkg::*;
#(
  parameter int CLK_HZ    = 10_000_000,
  parameter int T_GREEN_A = 10,
  parameter int T_GREEN_B = 5,
  parameter int T_YELLOW  = 2,
  parameter int T_ALLRED  = 1,
  parameter int T_WALK    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_req,
  input  logic       ped_req,
  output logic       a_red,
  output logic       a_yellow,
  output logic       a_green,
  output logic       b_red,
  output logic       b_yellow,
  output logic       b_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam int T_MAX1 = (T_GREEN_A > T_GREEN_B) ? T_GREEN_A : T_GREEN_B;
  localparam int T_MAX2 = (T_YELLOW > T_ALLRED) ? T_YELLOW : T_ALLRED;
  localparam int T_MAX3 = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
  localparam int T_MAX  = (T_MAX3 > T_WALK) ? T_MAX3 : T_WALK;
  localparam int SEC_W  = cnt_width(T_MAX + 1);

  state_t           state, state_nxt;
  dir_t             next_dir, dir_nxt;
  lamps_t           lamps;
  logic [SEC_W-1:0] sec_cnt, sec_limit;
  logic             tick, transition;
  logic             done_allred, done_yellow, done_green_b, done_walk, min_green_done;

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (transition),
    .tick (tick)
  );

  assign done_allred  = tick && (sec_cnt == SEC_W'(T_ALLRED - 1));
  assign done_yellow  = tick && (sec_cnt == SEC_W'(T_YELLOW - 1));
  assign done_green_b = tick && (sec_cnt == SEC_W'(T_GREEN_B - 1));
  assign done_walk    = tick && (sec_cnt == SEC_W'(T_WALK - 1));
  // Minimum green counts as met on its final tick too, so a waiting request exits with no extra cycle.
  assign min_green_done = (sec_cnt == SEC_W'(T_GREEN_A)) ||
                          (tick && (sec_cnt == SEC_W'(T_GREEN_A - 1)));

  always_comb begin
    state_nxt = state;
    dir_nxt   = next_dir;
    case (state)
      ALLRED_BA: begin
        if (done_allred) begin
          if (ped_pending) begin
            state_nxt = PED_WALK;
            dir_nxt   = DIR_A;
          end else begin
            state_nxt = A_GREEN;
          end
        end
      end
      A_GREEN:  if (min_green_done && (side_req || ped_pending)) state_nxt = A_YELLOW;
      A_YELLOW: if (done_yellow) state_nxt = ALLRED_AB;
      ALLRED_AB: begin
        if (done_allred) begin
          if (ped_pending) begin
            state_nxt = PED_WALK;
            dir_nxt   = DIR_B;
          end else begin
            state_nxt = B_GREEN;
          end
        end
      end
      B_GREEN:  if (done_green_b) state_nxt = B_YELLOW;
      B_YELLOW: if (done_yellow) state_nxt = ALLRED_BA;
      PED_WALK: if (done_walk) state_nxt = (next_dir == DIR_A) ? A_GREEN : B_GREEN;
      default:  state_nxt = ALLRED_BA;
    endcase
  end

  assign transition = (state_nxt != state);

  // A_GREEN holds the count at T_GREEN_A so min-green stays satisfied while waiting for demand.
  always_comb begin
    case (state)
      A_GREEN:            sec_limit = SEC_W'(T_GREEN_A);
      A_YELLOW, B_YELLOW: sec_limit = SEC_W'(T_YELLOW - 1);
      B_GREEN:            sec_limit = SEC_W'(T_GREEN_B - 1);
      PED_WALK:           sec_limit = SEC_W'(T_WALK - 1);
      default:            sec_limit = SEC_W'(T_ALLRED - 1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ALLRED_BA;
      next_dir <= DIR_A;
      sec_cnt  <= '0;
      lamps    <= lamp_decode(ALLRED_BA);
    end else begin
      state    <= state_nxt;
      next_dir <= dir_nxt;
      lamps    <= lamp_decode(state_nxt);
      if (transition) begin
        sec_cnt <= '0;
      end else if (tick && (sec_cnt != sec_limit)) begin
        sec_cnt <= sec_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pending <= 1'b0;
    end else if (state_nxt == PED_WALK && state != PED_WALK) begin
      ped_pending <= 1'b0;
    end else if (ped_req && state != PED_WALK) begin
      ped_pending <= 1'b1;
    end
  end

  assign a_red    = lamps.a_red;
  assign a_yellow = lamps.a_yellow;
  assign a_green  = lamps.a_green;
  assign b_red    = lamps.b_red;
  assign b_yellow = lamps.b_yellow;
  assign b_green  = lamps.b_green;
  assign walk     = lamps.walk;
  assign phase    = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: cycle-count phase model checked every cycle plus directed run-length checks.
module tb_traffic_phase_scheduler;

  localparam int HZ = 10;
  localparam int P_ARBA = 0, P_AG = 1, P_AY = 2, P_ARAB = 3, P_BG = 4, P_BY = 5, P_WALK = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic       a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk, ped_pending;
  logic [2:0] phase;

  int vectors = 0;
  int miscompares = 0;

  traffic_phase_scheduler #(
    .CLK_HZ(HZ), .T_GREEN_A(10), .T_GREEN_B(5), .T_YELLOW(2), .T_ALLRED(1), .T_WALK(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .side_req(side_req), .ped_req(ped_req),
    .a_red(a_red), .a_yellow(a_yellow), .a_green(a_green),
    .b_red(b_red), .b_yellow(b_yellow), .b_green(b_green),
    .walk(walk), .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Phase model: every phase is just a length in cycles; A green may leave once its minimum is served.
  int m_ph, m_cyc;
  bit m_pend, m_dir_b;

  function automatic int phase_cycles(input int ph);
    case (ph)
      P_AG:         return 10 * HZ;
      P_AY, P_BY:   return 2 * HZ;
      P_BG:         return 5 * HZ;
      P_WALK:       return 6 * HZ;
      default:      return 1 * HZ;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int nxt;
    bit served;
    if (!rst_n) begin
      m_ph = P_ARBA; m_cyc = 0; m_pend = 0; m_dir_b = 0;
    end else begin
      served = (m_cyc >= phase_cycles(m_ph) - 1);
      nxt = m_ph;
      case (m_ph)
        P_ARBA: if (served) begin nxt = m_pend ? P_WALK : P_AG; if (m_pend) m_dir_b = 0; end
        P_AG:   if (served && (side_req || m_pend)) nxt = P_AY;
        P_AY:   if (served) nxt = P_ARAB;
        P_ARAB: if (served) begin nxt = m_pend ? P_WALK : P_BG; if (m_pend) m_dir_b = 1; end
        P_BG:   if (served) nxt = P_BY;
        P_BY:   if (served) nxt = P_ARBA;
        default: if (served) nxt = m_dir_b ? P_BG : P_AG;
      endcase
      if (nxt == P_WALK && m_ph != P_WALK) m_pend = 0;
      else if (ped_req && m_ph != P_WALK) m_pend = 1;
      m_cyc = (nxt == m_ph) ? m_cyc + 1 : 0;
      m_ph = nxt;
    end
  end

  function automatic logic [10:0] model_vec();
    logic [10:0] v;
    v[10:8] = 3'(m_ph);
    v[7] = !(m_ph == P_AG || m_ph == P_AY);
    v[6] = (m_ph == P_AY);
    v[5] = (m_ph == P_AG);
    v[4] = !(m_ph == P_BG || m_ph == P_BY);
    v[3] = (m_ph == P_BY);
    v[2] = (m_ph == P_BG);
    v[1] = (m_ph == P_WALK);
    v[0] = m_pend;
    return v;
  endfunction

  always @(negedge clk) begin
    check("model_cmp", int'({phase, a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk, ped_pending}),
          int'(model_vec()));
  end

  // Run-length recorder of DUT phases, used for the literal duration checks.
  int run_ph[$];
  int run_len[$];
  int cur_ph = -1;
  int cur_len = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_ph = -1; cur_len = 0;
    end else if (int'(phase) == cur_ph) begin
      cur_len++;
    end else begin
      if (cur_ph >= 0) begin run_ph.push_back(cur_ph); run_len.push_back(cur_len); end
      cur_ph = int'(phase); cur_len = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_phase(input int ph, input int bound, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(phase) != ph && n < bound);
    #1;
    check(name, int'(phase), ph);
  endtask

  task automatic expect_run(input int ph, input int len, input string name);
    if (run_ph.size() == 0) begin
      check({name, "_present"}, 0, 1);
    end else begin
      check({name, "_phase"}, run_ph.pop_front(), ph);
      check({name, "_len"}, run_len.pop_front(), len);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    // Reset and start-up
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_phase(P_AG, 40, "startup_wait");
    expect_run(P_ARBA, 10, "startup_allred");
    check("startup_a_green", int'(a_green), 1);
    check("startup_b_red", int'(b_red), 1);

    // No demand: A holds green indefinitely
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (!(a_green && b_red && !b_green && !b_yellow)) bad++;
    end
    check("nodemand_bad_cycles", bad, 0);
    check("nodemand_phase", int'(phase), P_AG);

    // Late side request exits on the next edge
    side_req = 1'b1;
    wait_phase(P_BG, 200, "late_side_wait_b");
    side_req = 1'b0;
    expect_run(P_AG, 1001, "late_side_a_green");
    expect_run(P_AY, 20, "late_side_a_yellow");
    expect_run(P_ARAB, 10, "late_side_allred_ab");
    wait_phase(P_AG, 200, "late_side_back_a");
    expect_run(P_BG, 50, "late_side_b_green");
    expect_run(P_BY, 20, "late_side_b_yellow");
    expect_run(P_ARBA, 10, "late_side_allred_ba");

    // Side request at cycle 30 of A_GREEN
    repeat (30) step();
    side_req = 1'b1;
    wait_phase(P_BG, 300, "side30_wait_b");
    side_req = 1'b0;
    expect_run(P_AG, 100, "side30_a_green");
    expect_run(P_AY, 20, "side30_a_yellow");
    expect_run(P_ARAB, 10, "side30_allred_ab");

    // Pedestrian pulse mid B_GREEN
    repeat (25) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("pedB_pending_set", int'(ped_pending), 1);
    wait_phase(P_WALK, 200, "pedB_wait_walk");
    check("pedB_pending_clr", int'(ped_pending), 0);
    check("pedB_walk_reds", int'({walk, a_red, b_red}), 7);
    expect_run(P_BG, 50, "pedB_b_green");
    expect_run(P_BY, 20, "pedB_b_yellow");
    expect_run(P_ARBA, 10, "pedB_allred_ba");
    wait_phase(P_AG, 200, "pedB_back_a");
    expect_run(P_WALK, 60, "pedB_walk");

    // Pedestrian plus side request after minimum green
    repeat (110) step();
    ped_req = 1'b1;
    side_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_phase(P_WALK, 200, "pedside_wait_walk");
    side_req = 1'b0;
    repeat (10) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("pedside_walk_ignore", int'(ped_pending), 0);
    wait_phase(P_BG, 200, "pedside_wait_b");
    expect_run(P_AG, 111, "pedside_a_green");
    expect_run(P_AY, 20, "pedside_a_yellow");
    expect_run(P_ARAB, 10, "pedside_allred_ab");
    expect_run(P_WALK, 60, "pedside_walk");

    // Asynchronous reset mid B_GREEN
    repeat (20) step();
    #1 rst_n = 1'b0;
    #1;
    check("arst_lamps", int'({a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk, ped_pending}), 8'h90);
    check("arst_phase", int'(phase), P_ARBA);
    repeat (5) @(posedge clk);
    run_ph.delete();
    run_len.delete();
    #3 rst_n = 1'b1;
    wait_phase(P_AG, 40, "rerun_wait");
    expect_run(P_ARBA, 10, "rerun_allred");
    check("rerun_a_green", int'(a_green), 1);

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
